// File: rtl/reu_multi_if.sv
// reu_multi_if: bus bundle between the multi-channel REU and its surroundings.
//   DMA side : dma_req/dma_addr/dma_dout/dma_we out, dma_cycle/dma_din in
//   RAM side : ram_addr/ram_dout/ram_we/ram_cs out, ram_cycle/ram_din in
//   CPU side : cpu_addr/cpu_dout/cpu_we/cpu_cs in, cpu_din out
//   Status   : irq, busy_ch out
// modport master is the REU itself, modport slave is the system around it.
interface reu_multi_if;
    logic        dma_req;
    logic        dma_cycle;
    logic [15:0] dma_addr;
    logic [7:0]  dma_dout;
    logic [7:0]  dma_din;
    logic        dma_we;
    logic        ram_cycle;
    logic [24:0] ram_addr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        ram_we;
    logic        ram_cs;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_we;
    logic        cpu_cs;
    logic        irq;
    logic [1:0]  busy_ch;

    modport master (
        output dma_req, dma_addr, dma_dout, dma_we,
        input  dma_cycle, dma_din,
        output ram_addr, ram_dout, ram_we, ram_cs,
        input  ram_cycle, ram_din,
        input  cpu_addr, cpu_dout, cpu_we, cpu_cs,
        output cpu_din, irq, busy_ch
    );

    modport slave (
        input  dma_req, dma_addr, dma_dout, dma_we,
        output dma_cycle, dma_din,
        input  ram_addr, ram_dout, ram_we, ram_cs,
        output ram_cycle, ram_din,
        output cpu_addr, cpu_dout, cpu_we, cpu_cs,
        input  cpu_din, irq, busy_ch
    );
endinterface

// File: rtl/reu_multi.sv
// reu_multi: multi-channel RAM Expansion Unit DMA engine.
// CHANNELS register banks (stash / fetch / swap / verify) share one C64 DMA
// port and one expansion-RAM port through a round-robin arbiter.
// Ports:
//   clk, reset (sync, active-high), enable (0 holds the block in reset)
//   bus : reu_multi_if.master (DMA, RAM, CPU register window, irq, busy_ch)
// Build option: define REU_BYTE_INTERLEAVE_EN to re-arbitrate after every
// byte instead of running each granted channel to completion.
module reu_multi #(
    parameter int CHANNELS = 2,
    parameter int RAM_AW   = 24,
    parameter int C64_WAIT = 16,
    parameter int RAM_WAIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    reu_multi_if.master bus
);
    localparam int          CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [23:0] REU_MASK = 24'((32'd1 << RAM_AW) - 32'd1);
    localparam logic [3:0]  C_LAST   = 4'(C64_WAIT - 1);
    localparam logic [3:0]  R_LAST   = 4'(RAM_WAIT - 1);
    localparam logic [1:0]  U_END = 2'd0, U_C = 2'd1, U_R = 2'd2;

    typedef enum logic [2:0] {IDLE, GRANT, EVAL, PROC_C64, PROC_RAM, DONE} state_t;
    state_t state, state_nx;

    logic rst;
    assign rst = reset | ~enable;

    // per-channel register banks
    logic [CHANNELS-1:0][7:0]  cmd, intr, ctl;
    logic [CHANNELS-1:0][15:0] c64a, c64a_sh, len, len_sh;
    logic [CHANNELS-1:0][23:0] reua, reua_sh;
    logic [CHANNELS-1:0]       st_end, st_fault, trig, pend, irq_ch;

    logic [CW-1:0] cur, last, sel, idx;
    logic          any_pend;
    logic [2:0]    step;
    logic          acc_wr, c_act, r_act, we_c;
    logic [3:0]    wcnt;
    logic [7:0]    d0, d1;             // d0: C64 read / RAM write, d1: RAM read / C64 write
    logic [15:0]   dma_addr_q;
    logic [7:0]    dma_dout_q, ram_dout_q, cpu_din_q, rd_val;
    logic [24:0]   ram_addr_q;
    logic          ram_cs_q, ram_we_q, dma_req_q, irq_q;
    logic [1:0]    busy_q;
    logic          cs_q, we_q;
    logic [1:0]    uop;
    logic          uop_wr, mism, term;

    // CPU window decode
    logic [CW-1:0] cpu_ch;
    logic [4:0]    rsel;
    logic          ch_ok, cs_rise, ff00_rise, ch_busy;
    assign cpu_ch    = bus.cpu_addr[5 +: CW];
    assign rsel      = bus.cpu_addr[4:0];
    assign ch_ok     = int'(bus.cpu_addr[6:5]) < CHANNELS;
    assign cs_rise   = bus.cpu_cs & ~cs_q;
    assign ff00_rise = bus.cpu_we & ~we_q & (bus.cpu_addr == 16'hFF00);
    assign ch_busy   = (state != IDLE) && (cpu_ch == cur);

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            pend[i]   = cmd[i][7] & (cmd[i][4] | trig[i]);
            irq_ch[i] = intr[i][7] & |({st_end[i], st_fault[i]} & intr[i][6:5]);
        end
    end

    // round-robin: scan from last+CHANNELS down to last+1 so the nearest
    // channel after the last one served is the one left in sel
    always_comb begin
        sel      = last;
        idx      = last;
        any_pend = |pend;
        for (int i = CHANNELS; i >= 1; i--) begin
            idx = CW'((int'(last) + i) % CHANNELS);
            if (pend[idx]) sel = idx;
        end
    end

    // micro-op table: C64 reads land in d0, RAM reads in d1
    always_comb begin
        uop    = U_END;
        uop_wr = 1'b0;
        case (cmd[cur][1:0])
            2'd0: case (step)
                3'd0: uop = U_C;
                3'd1: begin uop = U_R; uop_wr = 1'b1; end
                default: ;
            endcase
            2'd1: case (step)
                3'd0: uop = U_R;
                3'd1: begin uop = U_C; uop_wr = 1'b1; end
                default: ;
            endcase
            2'd2: case (step)
                3'd0: uop = U_C;
                3'd1: uop = U_R;
                3'd2: begin uop = U_R; uop_wr = 1'b1; end
                3'd3: begin uop = U_C; uop_wr = 1'b1; end
                default: ;
            endcase
            default: case (step)
                3'd0: uop = U_C;
                3'd1: uop = U_R;
                default: ;
            endcase
        endcase
    end

    assign mism = (cmd[cur][1:0] == 2'd3) && (d0 != d1);
    assign term = (len[cur] == 16'd1) || mism;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (any_pend) state_nx = GRANT;
            GRANT:    state_nx = EVAL;
            EVAL: begin
                if (uop == U_C)      state_nx = PROC_C64;
                else if (uop == U_R) state_nx = PROC_RAM;
                else if (term)       state_nx = DONE;
                else
`ifdef REU_BYTE_INTERLEAVE_EN
                    state_nx = IDLE;
`else
                    state_nx = EVAL;
`endif
            end
            PROC_C64: if (c_act && bus.dma_cycle && wcnt == C_LAST) state_nx = EVAL;
            PROC_RAM: if (r_act && bus.ram_cycle && wcnt == R_LAST) state_nx = EVAL;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        rd_val = 8'hFF;
        if (ch_ok) begin
            case (rsel)
                5'd0:  rd_val = {irq_ch[cpu_ch], st_end[cpu_ch], st_fault[cpu_ch], 1'b1, 4'b0000};
                5'd1:  rd_val = cmd[cpu_ch];
                5'd2:  rd_val = c64a[cpu_ch][7:0];
                5'd3:  rd_val = c64a[cpu_ch][15:8];
                5'd4:  rd_val = reua[cpu_ch][7:0];
                5'd5:  rd_val = reua[cpu_ch][15:8];
                5'd6:  rd_val = reua[cpu_ch][23:16] | ~REU_MASK[23:16];
                5'd7:  rd_val = len[cpu_ch][7:0];
                5'd8:  rd_val = len[cpu_ch][15:8];
                5'd9:  rd_val = intr[cpu_ch];
                5'd10: rd_val = ctl[cpu_ch];
                default: rd_val = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd <= {CHANNELS{8'h10}};
            intr <= '0; ctl <= '0;
            c64a <= '0; c64a_sh <= '0; len <= '0; len_sh <= '0;
            reua <= '0; reua_sh <= '0;
            st_end <= '0; st_fault <= '0; trig <= '0;
            cur <= '0; last <= '0; step <= '0;
            acc_wr <= 1'b0; c_act <= 1'b0; r_act <= 1'b0; we_c <= 1'b0;
            wcnt <= '0; d0 <= '0; d1 <= '0;
            dma_addr_q <= '0; dma_dout_q <= '0; dma_req_q <= 1'b0;
            ram_addr_q <= '0; ram_dout_q <= '0; ram_cs_q <= 1'b0; ram_we_q <= 1'b0;
            cpu_din_q <= 8'hFF; irq_q <= 1'b0; busy_q <= '0;
            cs_q <= 1'b0; we_q <= 1'b0;
        end else begin
            cs_q  <= bus.cpu_cs;
            we_q  <= bus.cpu_we;
            irq_q <= |irq_ch;

            for (int i = 0; i < CHANNELS; i++)
                if (ff00_rise && cmd[i][7]) trig[i] <= 1'b1;

            // CPU register window
            if (cs_rise) begin
                if (bus.cpu_we) begin
                    if (ch_ok && !ch_busy) begin
                        case (rsel)
                            5'd1: begin cmd[cpu_ch] <= bus.cpu_dout; trig[cpu_ch] <= 1'b0; end
                            5'd2: begin c64a[cpu_ch][7:0]   <= bus.cpu_dout; c64a_sh[cpu_ch][7:0]   <= bus.cpu_dout; end
                            5'd3: begin c64a[cpu_ch][15:8]  <= bus.cpu_dout; c64a_sh[cpu_ch][15:8]  <= bus.cpu_dout; end
                            5'd4: begin reua[cpu_ch][7:0]   <= bus.cpu_dout; reua_sh[cpu_ch][7:0]   <= bus.cpu_dout; end
                            5'd5: begin reua[cpu_ch][15:8]  <= bus.cpu_dout; reua_sh[cpu_ch][15:8]  <= bus.cpu_dout; end
                            5'd6: begin reua[cpu_ch][23:16] <= bus.cpu_dout; reua_sh[cpu_ch][23:16] <= bus.cpu_dout; end
                            5'd7: begin len[cpu_ch][7:0]    <= bus.cpu_dout; len_sh[cpu_ch][7:0]    <= bus.cpu_dout; end
                            5'd8: begin len[cpu_ch][15:8]   <= bus.cpu_dout; len_sh[cpu_ch][15:8]   <= bus.cpu_dout; end
                            5'd9:  intr[cpu_ch] <= bus.cpu_dout;
                            5'd10: ctl[cpu_ch]  <= bus.cpu_dout;
                            default: ;
                        endcase
                    end
                end else begin
                    cpu_din_q <= rd_val;
                    if (ch_ok && rsel == 5'd0) begin
                        st_end[cpu_ch]   <= 1'b0;
                        st_fault[cpu_ch] <= 1'b0;
                    end
                end
            end

            // transfer engine; placed after the CPU block so termination wins
            case (state)
                IDLE: begin
                    if (any_pend) cur <= sel;
`ifdef REU_BYTE_INTERLEAVE_EN
                    dma_req_q <= any_pend;
`endif
                end
                GRANT: begin
                    reua[cur] <= reua[cur] & REU_MASK;
                    dma_req_q <= 1'b1;
                    busy_q    <= 2'(cur);
                    last      <= cur;
                    step      <= '0;
                end
                EVAL: begin
                    if (uop != U_END) begin
                        acc_wr <= uop_wr;
                        step   <= step + 3'd1;
                    end else begin
                        step <= '0;
                        if (!ctl[cur][7]) c64a[cur] <= c64a[cur] + 16'd1;
                        if (!ctl[cur][6]) reua[cur] <= (reua[cur] + 24'd1) & REU_MASK;
                        len[cur] <= len[cur] - 16'd1;
                        if (term) begin
                            st_end[cur] <= 1'b1;
                            if (mism) st_fault[cur] <= 1'b1;
                            cmd[cur][7] <= 1'b0;
                            cmd[cur][4] <= 1'b1;
                            trig[cur]   <= 1'b0;
                            if (cmd[cur][5]) begin
                                c64a[cur] <= c64a_sh[cur];
                                reua[cur] <= reua_sh[cur];
                                len[cur]  <= len_sh[cur];
                            end
                        end
                    end
                end
                PROC_C64: begin
                    if (!c_act) begin
                        if (!bus.dma_cycle) begin
                            c_act      <= 1'b1;
                            wcnt       <= '0;
                            dma_addr_q <= c64a[cur];
                            dma_dout_q <= d1;
                            we_c       <= acc_wr;
                        end
                    end else if (bus.dma_cycle) begin
                        if (wcnt == C_LAST) begin
                            c_act      <= 1'b0;
                            we_c       <= 1'b0;
                            dma_addr_q <= '0;
                            if (!acc_wr) d0 <= bus.dma_din;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                end
                PROC_RAM: begin
                    if (!r_act) begin
                        if (!bus.ram_cycle) begin
                            r_act      <= 1'b1;
                            wcnt       <= '0;
                            ram_cs_q   <= 1'b1;
                            ram_we_q   <= acc_wr;
                            ram_addr_q <= {1'b1, reua[cur]};
                            ram_dout_q <= d0;
                        end
                    end else if (bus.ram_cycle) begin
                        if (wcnt == R_LAST) begin
                            r_act    <= 1'b0;
                            ram_cs_q <= 1'b0;
                            ram_we_q <= 1'b0;
                            if (!acc_wr) d1 <= bus.ram_din;
                        end else begin
                            wcnt <= wcnt + 4'd1;
                        end
                    end
                end
                DONE:    dma_req_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.dma_req  = dma_req_q;
    assign bus.dma_addr = dma_addr_q;
    assign bus.dma_dout = dma_dout_q;
    assign bus.dma_we   = we_c & bus.dma_cycle;
    assign bus.ram_addr = ram_addr_q;
    assign bus.ram_dout = ram_dout_q;
    assign bus.ram_we   = ram_we_q;
    assign bus.ram_cs   = ram_cs_q;
    assign bus.cpu_din  = cpu_din_q;
    assign bus.irq      = irq_q;
    assign bus.busy_ch  = busy_q;
endmodule
